sram2149_master: RTL and testbench

- Initiator-side access sequencer that drives a bank of 2149-style 1Kx4 static RAMs with active-low CS_b/WE_b.
- Converts a valid/ready request port from the CPU/video side into correctly timed chip-select, write-enable and address strobes, and returns read data.
- Clears the whole bank to a fixed value after reset or on command.
- Sits between the bus decoder and the RAM instances; one master per bank.

---
 rtl/sram2149_master.sv | 126 ++++++++++++
 tb/tb_sram2149_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram2149_master.sv
// Access sequencer for a bank of 2149-style 1Kx4 SRAMs: turns a valid/ready
// request port into CS_b/WE_b/address strobes and can clear the whole bank.
module sram2149_master #(
  parameter int         ADDR_W         = 10,
  parameter int         NIBBLES        = 2,
  parameter logic [3:0] CLEAR_VAL      = 4'h0,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [4*NIBBLES-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [4*NIBBLES-1:0] rsp_rdata,
  input  logic                 clear_req,
  output logic                 init_done,
  output logic [ADDR_W-1:0]    ram_A,
  output logic                 ram_CS_b,
  output logic                 ram_WE_b,
  output logic [4*NIBBLES-1:0] ram_Din,
  input  logic [4*NIBBLES-1:0] ram_Dout
);
  localparam int                DW         = 4 * NIBBLES;
  localparam logic [ADDR_W-1:0] LAST_A     = '1;
  localparam logic [DW-1:0]     CLEAR_WORD = {NIBBLES{CLEAR_VAL}};

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACCESS, S_RESP} state_t;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; the source holds its fields stable until then.
  state_t            state, state_n;
  logic [ADDR_W-1:0] a_n;
  logic              cs_n, we_n, rv_n, done_n;
  logic [DW-1:0]     din_n, rd_n;

  assign req_ready = (state == S_IDLE) && !clear_req;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= RESET_STATE;
      ram_A     <= '0;
      ram_CS_b  <= 1'b1;
      ram_WE_b  <= 1'b1;
      ram_Din   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      ram_A     <= a_n;
      ram_CS_b  <= cs_n;
      ram_WE_b  <= we_n;
      ram_Din   <= din_n;
      rsp_valid <= rv_n;
      rsp_rdata <= rd_n;
      init_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = ram_A;
    cs_n    = ram_CS_b;
    we_n    = ram_WE_b;
    din_n   = ram_Din;
    rv_n    = 1'b0;
    rd_n    = rsp_rdata;
    done_n  = init_done;
    case (state)
      S_CLEAR: begin
        // Leaving reset the strobes are still deasserted: the first CLEAR
        // cycle only arms the write sweep at address 0.
        if (ram_CS_b) begin
          cs_n  = 1'b0;
          we_n  = 1'b0;
          a_n   = '0;
          din_n = CLEAR_WORD;
        end else if (ram_A == LAST_A) begin
          cs_n    = 1'b1;
          we_n    = 1'b1;
          a_n     = '0;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          a_n = ram_A + ADDR_W'(1);
        end
      end
      S_IDLE: begin
        done_n = 1'b1;
        cs_n   = 1'b1;
        we_n   = 1'b1;
        if (clear_req) begin
          cs_n    = 1'b0;
          we_n    = 1'b0;
          a_n     = '0;
          din_n   = CLEAR_WORD;
          state_n = S_CLEAR;
        end else if (req_valid) begin
          a_n     = req_addr;
          we_n    = !req_we;
          cs_n    = 1'b0;
          if (req_we) din_n = req_wdata;
          state_n = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cs_n = 1'b1;
        we_n = 1'b1;
        // Only a selected, non-writing device drives valid data.
        if (!ram_CS_b && ram_WE_b) begin
          rd_n    = ram_Dout;
          rv_n    = 1'b1;
          state_n = S_RESP;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = RESET_STATE;
    endcase
  end
endmodule

// File: tb/tb_sram2149_master.sv
// Bench for sram2149_master: a 1Kx8 device model on the RAM pins, a shadow
// memory with an expected-response queue, vector table plus random traffic.
module tb_sram2149_master;
  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       req_valid = 1'b0, req_we = 1'b0, clear_req = 1'b0;
  logic [9:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, init_done, ram_CS_b, ram_WE_b;
  logic [7:0] rsp_rdata, ram_Din;
  logic [9:0] ram_A;
  wire  [7:0] ram_Dout;

  sram2149_master #(.ADDR_W(10), .NIBBLES(2), .CLEAR_VAL(4'h0), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .clear_req(clear_req),
    .init_done(init_done), .ram_A(ram_A), .ram_CS_b(ram_CS_b), .ram_WE_b(ram_WE_b),
    .ram_Din(ram_Din), .ram_Dout(ram_Dout)
  );

  always #5 clk = ~clk;

  // Device model: write on rising edge while selected and write-enabled,
  // outputs float whenever it is not being read.
  logic [7:0] dev_mem [1024];
  always @(posedge clk) if (!ram_CS_b && !ram_WE_b) dev_mem[ram_A] <= ram_Din;
  assign ram_Dout = (!ram_CS_b && ram_WE_b) ? dev_mem[ram_A] : 8'bz;

  int n_tests = 0, n_fail = 0;
  logic [7:0] ref_mem [1024];
  logic [7:0] exp_q[$];
  bit   ready_log[$];
  bit   rec_en = 0, prev_rv = 0, xz_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
  endtask

  // Scoreboard: every response must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rst_b && $isunknown(rsp_rdata)) xz_seen = 1;
    if (rec_en) ready_log.push_back(req_ready);
    if (rst_b && rsp_valid) begin
      check("rsp_single_cycle", prev_rv, 0);
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_unexpected: got response %0h, expected none", rsp_rdata);
      end else check("rsp_rdata", rsp_rdata, exp_q.pop_front());
    end
    prev_rv = rst_b && rsp_valid;
  end

  // Call at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input bit we, input logic [9:0] addr, input logic [7:0] wd,
                       input logic [7:0] exp, input bit hold);
    int waited = 0;
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    while (!req_ready && waited < 50) begin @(negedge clk); waited++; end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL req_timeout: got no ready after %0d cycles, expected ready", waited);
    end else if (we) ref_mem[addr] = wd;
    else exp_q.push_back(exp);
    @(posedge clk); #1;
    if (!hold) req_valid = 0;
  endtask

  // Call at a negedge; returns at the first negedge after the sweep ends.
  task automatic run_clear_check(input bit first);
    int n = 0, guard = 0;
    bit addr_ok = 1, ready_ok = 1, din_ok = 1;
    while (!(ram_CS_b == 0 && ram_WE_b == 0) && guard < 10) begin @(negedge clk); guard++; end
    while (ram_CS_b == 0 && ram_WE_b == 0 && n < 2000) begin
      if (ram_A !== n[9:0]) addr_ok = 0;
      if (req_ready || (first && init_done)) ready_ok = 0;
      if (ram_Din !== 8'h00) din_ok = 0;
      n++;
      @(negedge clk);
    end
    check("clear_len", n, 1024);
    check("clear_addr_seq", addr_ok, 1);
    check("clear_ready_low", ready_ok, 1);
    check("clear_din", din_ok, 1);
    check("clear_done", {init_done, ram_CS_b, ram_WE_b}, 3'b111);
    check("clear_end_a", ram_A, 0);
    model_clear();
  endtask

  typedef struct { bit we; logic [9:0] addr; logic [7:0] wdata; logic [7:0] exp; } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 10'h000, 8'h3C, 8'h00};
    vecs[1] = '{1, 10'h3FF, 8'hC3, 8'h00};
    vecs[2] = '{0, 10'h000, 8'h00, 8'h3C};
    vecs[3] = '{0, 10'h3FF, 8'h00, 8'hC3};
    vecs[4] = '{0, 10'h200, 8'h00, 8'h00};
    vecs[5] = '{1, 10'h200, 8'h81, 8'h00};
    vecs[6] = '{1, 10'h200, 8'h7E, 8'h00};
    vecs[7] = '{0, 10'h200, 8'h00, 8'h7E};

    // Reset and power-on clear
    #1 rst_b = 0;
    @(negedge clk); @(negedge clk);
    check("rst_strobes", {ram_CS_b, ram_WE_b}, 2'b11);
    check("rst_a_din", {ram_A, ram_Din}, 0);
    check("rst_rsp", {rsp_valid, rsp_rdata}, 0);
    check("rst_init_ready", {init_done, req_ready}, 0);
    rst_b = 1;
    run_clear_check(1);
    @(posedge clk); #1;
    issue(0, 10'h3FF, 8'h00, ref_mem[10'h3FF], 0);

    // Write then read 0x155 with strobe and latency checks
    issue(1, 10'h155, 8'hA5, 8'h00, 0);
    @(negedge clk);
    check("wr_strobe_low", {ram_CS_b, ram_WE_b, ram_A, ram_Din}, {2'b00, 10'h155, 8'hA5});
    @(negedge clk);
    check("wr_strobe_high", {ram_CS_b, ram_WE_b}, 2'b11);
    @(posedge clk); #1;
    issue(0, 10'h155, 8'h00, 8'hA5, 0);
    @(negedge clk);
    check("rd_access", {ram_CS_b, ram_WE_b, rsp_valid}, 3'b010);
    @(negedge clk);
    check("rd_latency", {rsp_valid, rsp_rdata}, {1'b1, 8'hA5});
    @(posedge clk); #1;

    // Back-to-back with req_valid held
    rec_en = 1;
    issue(1, 10'h001, 8'h12, 8'h00, 1);
    issue(0, 10'h001, 8'h00, 8'h12, 1);
    issue(1, 10'h002, 8'h34, 8'h00, 1);
    issue(0, 10'h002, 8'h00, 8'h34, 0);
    @(negedge clk); @(negedge clk); #1 rec_en = 0;
    begin
      logic [9:0] pat = '0;
      foreach (ready_log[i]) pat = {pat[8:0], ready_log[i]};
      check("b2b_ready_len", ready_log.size(), 10);
      check("b2b_ready_pat", pat, 10'b1010010100);
    end
    @(posedge clk); #1;

    // Vector table
    foreach (vecs[i]) issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 0);

    // Floating device outputs around a read of 8'h5A
    issue(1, 10'h2AA, 8'h5A, 8'h00, 0);
    issue(0, 10'h2AA, 8'h00, 8'h5A, 0);
    @(negedge clk); @(negedge clk);
    check("z_read", rsp_rdata, 8'h5A);
    @(posedge clk); #1;

    // Random traffic against the shadow memory
    begin
      logic [9:0] pool [16];
      foreach (pool[i]) pool[i] = 10'($urandom_range(0, 1023));
      for (int i = 0; i < 200; i++) begin
        logic [9:0] a;
        bit w;
        a = pool[$urandom_range(0, 15)];
        w = ($urandom_range(0, 1) == 1);
        issue(w, a, 8'($urandom), ref_mem[a], 0);
      end
    end
    repeat (4) @(posedge clk);
    #1;

    // clear_req wins over a simultaneous write
    clear_req = 1; req_valid = 1; req_we = 1; req_addr = 10'h010; req_wdata = 8'hFF;
    @(negedge clk);
    check("collide_ready", req_ready, 0);
    @(posedge clk); #1;
    clear_req = 0; req_valid = 0;
    @(negedge clk);
    run_clear_check(0);
    @(posedge clk); #1;
    issue(0, 10'h010, 8'h00, ref_mem[10'h010], 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset pulsed in the middle of a clear
    clear_req = 1;
    @(posedge clk); #1 clear_req = 0;
    begin
      int g = 0;
      @(negedge clk);
      while (ram_A != 10'h200 && g < 2000) begin @(negedge clk); g++; end
      check("midclr_reach", ram_A, 10'h200);
    end
    #1 rst_b = 0;
    #1;
    check("midclr_rst_strobes", {ram_CS_b, ram_WE_b, ram_A}, {2'b11, 10'h000});
    check("midclr_rst_done", {init_done, rsp_valid}, 2'b00);
    @(negedge clk); rst_b = 1;
    run_clear_check(1);
    @(posedge clk); #1;
    issue(0, 10'h155, 8'h00, ref_mem[10'h155], 0);
    repeat (4) @(posedge clk);
    @(negedge clk);

    check("exp_q_drained", exp_q.size(), 0);
    check("no_xz_rdata", xz_seen, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end
endmodule
